output_stream_buffer: RTL

Buffers the accelerator's result records between the MAC/adder-tree output stage and the chip's external output interface. Each accepted record holds the 16-bit result, its x, y and output-channel coordinates, and stays in a DEPTH-entry FIFO. Records drain as packed 48-bit words over a valid/ready handshake. Because the producer has no ready input, the block raises `almost_full` so the controller can stall, and counts any records dropped on overflow.

---
 rtl/output_stream_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/output_stream_buffer.sv
// output_stream_buffer
//   Holds result records from the MAC/adder-tree output stage until the
//   external output interface accepts them. Records are stored in a
//   DEPTH-entry first-word-fall-through FIFO and leave as packed 48-bit words
//   over a valid/ready handshake. The producer cannot be back-pressured
//   directly, so almost_full warns the controller early. Records that arrive
//   while the FIFO is full are dropped and counted.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   arst_in    : asynchronous active-high reset
//   in_valid   : record present this cycle
//   in_data    : signed result
//   in_x/in_y  : feature-map coordinates
//   in_ch      : output channel
//   almost_full: stall request, count >= DEPTH - ALMOST_FULL_MARGIN
//   overflow   : sticky, set when a record is dropped
//   drop_count : dropped records, saturating at 16'hFFFF
//   count      : current occupancy
//   out_valid  : head entry available
//   out_ready  : downstream accepts the word
//   out_word   : packed head record {0, ch, y, x, data}, 0 while empty
module output_stream_buffer #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_MARGIN = 2,
  localparam int XW   = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW   = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW   = $clog2(OUTPUT_NB_CHANNELS),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [XW-1:0]         in_x,
  input  logic [YW-1:0]         in_y,
  input  logic [CW-1:0]         in_ch,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [CNTW-1:0]       count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [47:0]           out_word
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + XW + YW + CW;

  if (EW > 48) begin : g_chk_width
    $error("output_stream_buffer: record width %0d exceeds 48 bits", EW);
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("output_stream_buffer: DEPTH must be a power of 2 and >= 2");
  end
  if (ALMOST_FULL_MARGIN >= DEPTH) begin : g_chk_margin
    $error("output_stream_buffer: ALMOST_FULL_MARGIN must be less than DEPTH");
  end

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            full, empty, pop, push, drop;
  logic [EW-1:0]   wr_entry;
  logic [47:0]     head_word;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;

  assign wr_entry = {in_ch, in_y, in_x, in_data};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Array contents are not reset; the output mask below hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head_word   = 48'(mem_q[rd_ptr_q]);
  assign out_word    = empty ? '0 : head_word;
  assign out_valid   = !empty;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;
  assign almost_full = (count_q >= CNTW'(DEPTH - ALMOST_FULL_MARGIN));

endmodule
